noc_output_arbiter: RTL and testbench
=====================================

Name: noc_output_arbiter

Overview:
- Merge side of the router crossbar: takes the five per-direction flit channels produced by the route selectors (X+, X-, Y+, Y-, local) destined for one output port and multiplexes them onto that port's single output channel.
- Arbitration is round-robin at packet granularity. A grant is locked from header acceptance until the tail flit is handshaken, so packets never interleave.
- A small output FIFO registers the merged stream and decouples downstream backpressure.

Parameters:
- CONFIG, NOC_DEFAULT_CONFIG, NoC configuration (flit width, id widths); shared with noc_flit_channel_if.
- CHANNELS, 5, number of input channels; the index of each input is its round-robin position.
- FIFO_DEPTH, 2, output FIFO entries; must be >= 1.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- flit_in_if[CHANNELS]  noc_flit_channel_if.target  valid/ready/flit per CONFIG  input channels from the route selectors.
- flit_out_if  noc_flit_channel_if.initiator  valid/ready/flit per CONFIG  merged output channel.

Behaviour:
- **Reset:** rst sampled on the clk edge.
  - FIFO emptied, so flit_out_if.valid=0.
  - State IDLE, grant vector 0.
  - Round-robin pointer = 0, so input 0 has highest priority.
  - All flit_in_if.ready=0 while rst=1.
  - Reset mid-packet discards the FIFO contents and the lock; there is no recovery of partial packets.
- **States:**
  - IDLE: no lock held.
  - BUSY: one input locked.
- **Request:** request[i] = flit_in_if[i].valid && is_header_flit(flit_in_if[i].flit).
- **IDLE arbitration (combinational, same cycle):**
  - Search starts at the pointer and wraps modulo CHANNELS.
  - The first requester found wins.
  - The winner's ready = !fifo_full.
- **Header accepted (winner valid && ready):**
  - pointer <= (winner+1) mod CHANNELS.
  - If the header is not also a tail: lock winner, go to BUSY.
  - If the header is also a tail (single-flit packet): stay IDLE, no lock.
- **Header blocked:** if the FIFO is full in IDLE, nothing is accepted and neither the pointer nor the state changes. The winner is re-evaluated each cycle.
- **BUSY:**
  - Only the locked input sees ready = !fifo_full. All others have ready=0.
  - Valid gaps on the locked input are tolerated; the lock holds.
  - A tail flit handshake returns the state to IDLE next cycle. The next arbitration happens in the cycle after the tail.
- **Non-requesting inputs:** ready is 0 on non-granted inputs at all times. Non-header flits on an unlocked input are not accepted (protocol violation, not flagged).
- **Ready path:** ready depends on !fifo_full only; there is no same-cycle bypass of a pop into ready.
- **Output FIFO:**
  - Push when a granted input handshakes; pop when flit_out_if.valid && ready.
  - Simultaneous push/pop when non-empty and non-full keeps the count unchanged.
  - Pointers wrap at FIFO_DEPTH.
  - Order is preserved.
- **Output signals:** flit_out_if.valid = !empty; flit_out_if.flit = FIFO head.
- **Latency:** input handshake at cycle N gives the flit on flit_out_if at N+1 with valid=1 (FIFO empty, downstream ready).
- **Throughput:** 1 flit/cycle sustained when downstream ready=1 and FIFO_DEPTH>=2. With FIFO_DEPTH=1 it is 1 flit per 2 cycles.

Test Plan:
- **Single packet:** reset, then input 2 sends a 3-flit packet (H,P,T), downstream ready=1.
  - flit_out_if carries H,P,T on cycles N+1..N+3.
  - Pointer becomes 3.
  - Inputs 0,1,3,4 have ready=0 throughout.
- **Contention:** inputs 0 and 3 both present a 2-flit header in the same cycle after reset.
  - Input 0 wins; its two flits are output first.
  - Input 3's header is accepted the cycle after input 0's tail.
  - Output order: 0H,0T,3H,3T; pointer ends at 4.
- **Round-robin wrap:** pointer=4; inputs 0 and 4 request with single-flit (header+tail) packets.
  - Input 4 wins, pointer becomes 0, state stays IDLE.
  - Input 0 is granted next cycle.
- **Backpressure:** FIFO_DEPTH=2, downstream ready=0, input 1 sends a 4-flit packet.
  - 2 flits are accepted, then input 1 ready=0.
  - Release ready: all 4 flits emerge in order, with no duplication or loss.
- **Lock with valid gap:** input 2 sends H, drops valid for 3 cycles, then sends T. Input 0 requests during the gap.
  - Input 0's ready stays 0 until the cycle after input 2's T handshake.
- **Reset mid-packet:** input 1 H and P accepted, rst=1 for one cycle.
  - Next cycle: flit_out_if.valid=0, state IDLE, pointer 0.
  - A new header on input 4 is accepted.

Source files
------------

// File: rtl/noc_output_arbiter_if.sv
// Shared NoC configuration and the valid/ready flit channel used on every router port.
package noc_pkg;

    // Id/payload widths; a flit is {head, tail, src_id, dst_id, payload}
    typedef struct packed {
        int unsigned id_w;
        int unsigned data_w;
    } noc_cfg_t;

    localparam noc_cfg_t NOC_DEFAULT_CONFIG = '{id_w: 32'd2, data_w: 32'd8};

    // Framing flags occupy the two MSBs of every flit
    typedef struct packed {
        logic head;
        logic tail;
    } flit_flags_t;

endpackage

interface noc_flit_channel_if
    import noc_pkg::*;
#(
    parameter noc_cfg_t CONFIG = NOC_DEFAULT_CONFIG
) ();

    localparam int unsigned FLIT_W = 32'd2 + 32'd2 * CONFIG.id_w + CONFIG.data_w;

    logic              valid;
    logic              ready;
    logic [FLIT_W-1:0] flit;

    modport initiator (output valid, output flit, input ready);
    modport target    (input valid, input flit, output ready);

endinterface

// File: rtl/noc_output_arbiter.sv
// Packet-granular round-robin merge of per-direction flit channels onto one output FIFO.
module noc_output_arbiter
    import noc_pkg::*;
#(
    parameter noc_cfg_t    CONFIG     = NOC_DEFAULT_CONFIG,
    parameter int unsigned CHANNELS   = 5,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    noc_flit_channel_if.target    flit_in_if [CHANNELS],
    noc_flit_channel_if.initiator flit_out_if
);

    localparam int unsigned FLIT_W = 32'd2 + 32'd2 * CONFIG.id_w + CONFIG.data_w;
    localparam int unsigned IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        lock_q, lock_d;
    logic [IDX_W-1:0]        rr_q, rr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    out_valid_q, out_valid_d;
    logic [FLIT_W-1:0]       mem_q [FIFO_DEPTH];
    logic [FLIT_W-1:0]       mem_d [FIFO_DEPTH];

    logic [CHANNELS-1:0]     valid_c;
    logic [CHANNELS-1:0]     request_c;
    logic [CHANNELS-1:0]     ready_c;
    logic [FLIT_W-1:0]       flit_c [CHANNELS];
    logic [IDX_W-1:0]        winner_c;
    logic                    win_found_c;
    logic [IDX_W-1:0]        grant_idx_c;
    logic                    granted_c;
    logic                    fifo_full_c;
    logic                    push_c;
    logic                    pop_c;
    logic [FLIT_W-1:0]       push_flit_c;
    flit_flags_t             push_flags_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Flatten the interface array into plain vectors; drive ready back per channel
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        flit_flags_t flags_c;
        assign valid_c[g]          = flit_in_if[g].valid;
        assign flit_c[g]           = flit_in_if[g].flit;
        assign flags_c             = flit_in_if[g].flit[FLIT_W-1 -: 2];
        assign request_c[g]        = flit_in_if[g].valid && flags_c.head;
        assign flit_in_if[g].ready = ready_c[g];
    end

    // Round-robin search starting at the pointer, wrapping modulo CHANNELS
    always_comb begin
        int unsigned pos;
        logic [IDX_W-1:0] idx;
        win_found_c = 1'b0;
        winner_c    = '0;
        pos         = 0;
        idx         = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            pos = 32'(rr_q) + k;
            if (pos >= CHANNELS) pos = pos - CHANNELS;
            idx = IDX_W'(pos);
            if (!win_found_c && request_c[idx]) begin
                win_found_c = 1'b1;
                winner_c    = idx;
            end
        end
    end

    // Grant, lock FSM, pointer update and FIFO bookkeeping
    always_comb begin
        state_d     = state_q;
        lock_d      = lock_q;
        rr_d        = rr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        mem_d       = mem_q;
        ready_c     = '0;

        fifo_full_c = (count_q == CNT_W'(FIFO_DEPTH));
        granted_c   = (state_q == BUSY) || win_found_c;
        grant_idx_c = (state_q == BUSY) ? lock_q : winner_c;

        if (!rst && granted_c && !fifo_full_c) ready_c[grant_idx_c] = 1'b1;

        push_c       = |(ready_c & valid_c);
        push_flit_c  = flit_c[grant_idx_c];
        push_flags_c = push_flit_c[FLIT_W-1 -: 2];
        pop_c        = out_valid_q && flit_out_if.ready;

        case (state_q)
            IDLE: begin
                if (push_c) begin
                    rr_d = (winner_c == IDX_W'(CHANNELS - 1)) ? '0 : winner_c + IDX_W'(1);
                    if (!push_flags_c.tail) begin
                        lock_d  = winner_c;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (push_c && push_flags_c.tail) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (push_c) begin
            mem_d[wr_ptr_q] = push_flit_c;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_c) rd_ptr_d = ptr_inc(rd_ptr_q);

        if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
        else if (!push_c && pop_c) count_d = count_q - CNT_W'(1);

        out_valid_d = (count_d != '0);
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lock_q      <= '0;
            rr_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_q      <= lock_d;
            rr_q        <= rr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
        end
    end

    // FIFO storage needs no reset; nothing is pushed while rst is high
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign flit_out_if.valid = out_valid_q;
    assign flit_out_if.flit  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed vector bench for noc_output_arbiter (5 channels, 2-entry FIFO).
module tb_noc_output_arbiter;
    import noc_pkg::*;

    localparam int unsigned FW = 14;

    typedef struct {
        string           grp;
        logic            rst;
        logic            ordy;
        logic [4:0]      valid;
        logic [4:0][FW-1:0] flits;
        logic [4:0]      e_ready;
        logic            e_ov;
        logic [FW-1:0]   e_of;
        int              e_rr;
    } vec_t;

    logic clk = 1'b0;
    logic tb_rst;
    logic tb_ordy;
    logic [4:0] tb_valid;
    logic [4:0][FW-1:0] tb_flit;
    logic [4:0] tb_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    noc_flit_channel_if #(.CONFIG(NOC_DEFAULT_CONFIG)) in_if [5] ();
    noc_flit_channel_if #(.CONFIG(NOC_DEFAULT_CONFIG)) out_if ();

    for (genvar g = 0; g < 5; g++) begin : g_drv
        assign in_if[g].valid = tb_valid[g];
        assign in_if[g].flit  = tb_flit[g];
        assign tb_ready[g]    = in_if[g].ready;
    end
    assign out_if.ready = tb_ordy;

    noc_output_arbiter #(
        .CONFIG    (NOC_DEFAULT_CONFIG),
        .CHANNELS  (5),
        .FIFO_DEPTH(2)
    ) dut (
        .clk        (clk),
        .rst        (tb_rst),
        .flit_in_if (in_if),
        .flit_out_if(out_if)
    );

    function automatic logic [FW-1:0] fl(input logic h, input logic t, input int ch, input int seq);
        return {h, t, 4'b0000, 4'(ch), 4'(seq)};
    endfunction
    function automatic logic [FW-1:0] H(input int ch, input int s);  return fl(1'b1, 1'b0, ch, s); endfunction
    function automatic logic [FW-1:0] P(input int ch, input int s);  return fl(1'b0, 1'b0, ch, s); endfunction
    function automatic logic [FW-1:0] T(input int ch, input int s);  return fl(1'b0, 1'b1, ch, s); endfunction
    function automatic logic [FW-1:0] HT(input int ch, input int s); return fl(1'b1, 1'b1, ch, s); endfunction

    function automatic vec_t mk(input string grp, input logic rst, input logic ordy,
                                input int ca, input logic [FW-1:0] fa,
                                input int cb, input logic [FW-1:0] fb,
                                input logic [4:0] er, input logic eov,
                                input logic [FW-1:0] eof, input int err);
        vec_t v;
        v.grp = grp; v.rst = rst; v.ordy = ordy;
        v.valid = '0; v.flits = '0;
        if (ca >= 0) begin v.valid[3'(ca)] = 1'b1; v.flits[3'(ca)] = fa; end
        if (cb >= 0) begin v.valid[3'(cb)] = 1'b1; v.flits[3'(cb)] = fb; end
        v.e_ready = er; v.e_ov = eov; v.e_of = eof; v.e_rr = err;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, got, want);
        end
    endtask

    vec_t vecs[$];
    localparam int N = -1;
    localparam logic [FW-1:0] Z = '0;

    initial begin
        logic [FW-1:0] pkt [6];

        // grp, rst, ordy, chA, flitA, chB, flitB, exp_ready, exp_ovalid, exp_oflit, exp_rr
        vecs.push_back(mk("reset",   1, 1, 2, H(2,0), N, Z, 5'b00000, 0, Z, 0));
        vecs.push_back(mk("single",  0, 1, 2, H(2,0), N, Z, 5'b00100, 0, Z, 0));
        vecs.push_back(mk("single",  0, 1, 2, P(2,1), N, Z, 5'b00100, 1, H(2,0), 3));
        vecs.push_back(mk("single",  0, 1, 2, T(2,2), N, Z, 5'b00100, 1, P(2,1), 3));
        vecs.push_back(mk("single",  0, 1, N, Z, N, Z, 5'b00000, 1, T(2,2), 3));
        vecs.push_back(mk("single",  0, 1, N, Z, N, Z, 5'b00000, 0, Z, 3));
        vecs.push_back(mk("contend", 1, 1, N, Z, N, Z, 5'b00000, 0, Z, 3));
        vecs.push_back(mk("contend", 0, 1, 0, H(0,0), 3, H(3,0), 5'b00001, 0, Z, 0));
        vecs.push_back(mk("contend", 0, 1, 0, T(0,1), 3, H(3,0), 5'b00001, 1, H(0,0), 1));
        vecs.push_back(mk("contend", 0, 1, 3, H(3,0), N, Z, 5'b01000, 1, T(0,1), 1));
        vecs.push_back(mk("contend", 0, 1, 3, T(3,1), N, Z, 5'b01000, 1, H(3,0), 4));
        vecs.push_back(mk("contend", 0, 1, N, Z, N, Z, 5'b00000, 1, T(3,1), 4));
        vecs.push_back(mk("wrap",    0, 1, 0, HT(0,2), 4, HT(4,0), 5'b10000, 0, Z, 4));
        vecs.push_back(mk("wrap",    0, 1, 0, HT(0,2), N, Z, 5'b00001, 1, HT(4,0), 0));
        vecs.push_back(mk("wrap",    0, 1, N, Z, N, Z, 5'b00000, 1, HT(0,2), 1));
        vecs.push_back(mk("wrap",    0, 1, N, Z, N, Z, 5'b00000, 0, Z, 1));
        vecs.push_back(mk("bp",      0, 0, 1, H(1,0), N, Z, 5'b00010, 0, Z, 1));
        vecs.push_back(mk("bp",      0, 0, 1, P(1,1), N, Z, 5'b00010, 1, H(1,0), 2));
        vecs.push_back(mk("bp",      0, 0, 1, P(1,2), N, Z, 5'b00000, 1, H(1,0), 2));
        vecs.push_back(mk("bp",      0, 0, 1, P(1,2), N, Z, 5'b00000, 1, H(1,0), 2));
        vecs.push_back(mk("bp",      0, 1, 1, P(1,2), N, Z, 5'b00000, 1, H(1,0), 2));
        vecs.push_back(mk("bp",      0, 1, 1, P(1,2), N, Z, 5'b00010, 1, P(1,1), 2));
        vecs.push_back(mk("bp",      0, 1, 1, T(1,3), N, Z, 5'b00010, 1, P(1,2), 2));
        vecs.push_back(mk("bp",      0, 1, N, Z, N, Z, 5'b00000, 1, T(1,3), 2));
        vecs.push_back(mk("bp",      0, 1, N, Z, N, Z, 5'b00000, 0, Z, 2));
        vecs.push_back(mk("gap",     0, 1, 2, H(2,4), N, Z, 5'b00100, 0, Z, 2));
        vecs.push_back(mk("gap",     0, 1, 0, H(0,4), N, Z, 5'b00100, 1, H(2,4), 3));
        vecs.push_back(mk("gap",     0, 1, 0, H(0,4), N, Z, 5'b00100, 0, Z, 3));
        vecs.push_back(mk("gap",     0, 1, 0, H(0,4), N, Z, 5'b00100, 0, Z, 3));
        vecs.push_back(mk("gap",     0, 1, 2, T(2,5), 0, H(0,4), 5'b00100, 0, Z, 3));
        vecs.push_back(mk("gap",     0, 1, 0, H(0,4), N, Z, 5'b00001, 1, T(2,5), 3));
        vecs.push_back(mk("gap",     0, 1, 0, T(0,5), N, Z, 5'b00001, 1, H(0,4), 1));
        vecs.push_back(mk("gap",     0, 1, N, Z, N, Z, 5'b00000, 1, T(0,5), 1));
        vecs.push_back(mk("gap",     0, 1, N, Z, N, Z, 5'b00000, 0, Z, 1));
        vecs.push_back(mk("midrst",  0, 0, 1, H(1,6), N, Z, 5'b00010, 0, Z, 1));
        vecs.push_back(mk("midrst",  0, 0, 1, P(1,7), N, Z, 5'b00010, 1, H(1,6), 2));
        vecs.push_back(mk("midrst",  1, 0, 1, P(1,8), N, Z, 5'b00000, 1, H(1,6), 2));
        vecs.push_back(mk("midrst",  0, 1, 4, H(4,0), N, Z, 5'b10000, 0, Z, 0));
        vecs.push_back(mk("midrst",  0, 1, 4, T(4,1), N, Z, 5'b10000, 1, H(4,0), 0));
        vecs.push_back(mk("midrst",  0, 1, N, Z, N, Z, 5'b00000, 1, T(4,1), 0));
        vecs.push_back(mk("midrst",  0, 1, N, Z, N, Z, 5'b00000, 0, Z, 0));

        tb_rst = 1'b1; tb_ordy = 1'b1; tb_valid = '0; tb_flit = '0;
        repeat (2) @(posedge clk);

        // Table: drive after the edge, sample on the falling edge
        foreach (vecs[i]) begin
            #1;
            tb_rst   = vecs[i].rst;
            tb_ordy  = vecs[i].ordy;
            tb_valid = vecs[i].valid;
            tb_flit  = vecs[i].flits;
            @(negedge clk);
            check({vecs[i].grp, ".ready"}, i, 32'(tb_ready), 32'(vecs[i].e_ready));
            check({vecs[i].grp, ".out_valid"}, i, 32'(out_if.valid), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov) check({vecs[i].grp, ".out_flit"}, i, 32'(out_if.flit), 32'(vecs[i].e_of));
            check({vecs[i].grp, ".rr_ptr"}, i, 32'(dut.rr_q), 32'(vecs[i].e_rr));
            @(posedge clk);
        end

        // Streaming: 6-flit packet on input 3 must flow at one flit per cycle
        pkt[0] = H(3,0); pkt[1] = P(3,1); pkt[2] = P(3,2);
        pkt[3] = P(3,3); pkt[4] = P(3,4); pkt[5] = T(3,5);
        for (int i = 0; i < 8; i++) begin
            #1;
            tb_rst = 1'b0; tb_ordy = 1'b1;
            tb_valid = (i < 6) ? 5'b01000 : 5'b00000;
            tb_flit = '0;
            if (i < 6) tb_flit[3] = pkt[i];
            @(negedge clk);
            check("stream.ready", i, 32'(tb_ready), (i < 6) ? 32'h8 : 32'h0);
            if (i >= 1 && i <= 6) begin
                check("stream.out_valid", i, 32'(out_if.valid), 32'h1);
                check("stream.out_flit", i, 32'(out_if.flit), 32'(pkt[i-1]));
            end else begin
                check("stream.out_valid", i, 32'(out_if.valid), 32'h0);
            end
            @(posedge clk);
        end
        #1;
        check("stream.rr_ptr", 0, 32'(dut.rr_q), 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
